// File: rtl/panda_top_bench.sv
`default_nettype none
// ============================================================================
// Module      : panda_top_bench
// Description : Position-capture top. Synchronises the TTL pads, timestamps
//               gated capture edges into a two-word-per-sample FIFO and
//               exposes control, status and interrupt over a register bus.
// Revision    : 1.0 - initial release
// ============================================================================
module panda_top_bench #(
  parameter int FIFO_DEPTH = 32,
  parameter int THRESH     = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [5:0]  ttlin_pad,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        irq_o
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;

  localparam logic [c_lvl_w-1:0] c_depth  = c_lvl_w'(FIFO_DEPTH);
  localparam logic [c_lvl_w-1:0] c_thresh = c_lvl_w'(THRESH);
  localparam logic [c_lvl_w-1:0] c_lvl_1  = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0] c_lvl_2  = c_lvl_w'(2);

  localparam logic [3:0] c_addr_arm    = 4'd0;
  localparam logic [3:0] c_addr_disarm = 4'd1;
  localparam logic [3:0] c_addr_mask   = 4'd2;
  localparam logic [3:0] c_addr_fen    = 4'd3;
  localparam logic [3:0] c_addr_irq    = 4'd4;
  localparam logic [3:0] c_addr_ack    = 4'd5;
  localparam logic [3:0] c_addr_data   = 4'd6;
  localparam logic [3:0] c_addr_smpl   = 4'd7;
  localparam logic [3:0] c_addr_status = 4'd8;

  logic [5:0]         r_sync1, r_ttl_s, r_ttl_d;
  logic               r_armed, r_fen;
  logic [5:0]         r_mask;
  logic [2:0]         r_irq_status;
  logic [15:0]        r_smpl;
  logic [31:0]        r_ts, r_fc, r_rdata;
  logic [c_ptr_w-1:0] r_wp, r_rp;
  logic [c_lvl_w-1:0] r_level;
  logic [31:0]        r_mem [FIFO_DEPTH];

  logic               w_gate_rise, w_gate_fall, w_cap_edge, w_capture;
  logic               w_wr_arm, w_wr_disarm, w_wr_ack, w_rd_data;
  logic               w_push, w_pop, w_ovf, w_thr_set, w_complete, w_room;
  logic [c_lvl_w-1:0] w_level_next;
  logic [c_ptr_w-1:0] w_wp1;
  logic [2:0]         w_ack_mask;
  logic [31:0]        w_ts_next, w_fc_next, w_word0, w_word1, w_rdata;
  logic               w_unused;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync1 <= '0;
      r_ttl_s <= '0;
      r_ttl_d <= '0;
    end else begin
      r_sync1 <= ttlin_pad;
      r_ttl_s <= r_sync1;
      r_ttl_d <= r_ttl_s;
    end
  end

  assign w_gate_rise = r_ttl_s[0] & ~r_ttl_d[0];
  assign w_gate_fall = ~r_ttl_s[0] & r_ttl_d[0];
  assign w_cap_edge  = r_ttl_s[2] & ~r_ttl_d[2];
  // Gate qualifier is the prior-cycle level so an edge coincident with the gate fall is kept
  assign w_capture   = r_armed & r_ttl_d[0] & w_cap_edge;

  assign w_wr_arm    = reg_wr && (reg_addr == c_addr_arm);
  assign w_wr_disarm = reg_wr && (reg_addr == c_addr_disarm);
  assign w_wr_ack    = reg_wr && (reg_addr == c_addr_ack);
  assign w_rd_data   = reg_rd && (reg_addr == c_addr_data);

  assign w_room       = (c_depth - r_level) >= c_lvl_2;
  assign w_push       = w_capture & w_room & ~w_wr_arm;
  assign w_ovf        = w_capture & ~w_room & ~w_wr_arm;
  assign w_pop        = w_rd_data & (r_level != '0);
  assign w_level_next = r_level + (w_push ? c_lvl_2 : '0) - (w_pop ? c_lvl_1 : '0);
  assign w_thr_set    = (w_level_next >= c_thresh) && (r_level < c_thresh);
  assign w_complete   = r_armed & (w_wr_disarm | w_gate_fall);
  assign w_ack_mask   = w_wr_ack ? reg_wdata[2:0] : 3'b000;
  assign w_wp1        = r_wp + c_ptr_w'(1);

  always_comb begin
    w_ts_next = r_ts;
    w_fc_next = r_fc;
    if (r_armed && w_gate_rise) begin
      w_ts_next = '0;
      w_fc_next = '0;
    end else if (r_armed && r_ttl_s[0]) begin
      if (r_ts != '1) w_ts_next = r_ts + 32'd1;
      if (r_fc != '1) w_fc_next = r_fc + 32'd1;
    end
  end

  // The sample carries the count including the capture cycle itself
  assign w_word0 = r_fen ? w_fc_next : w_ts_next;
  assign w_word1 = {26'b0, r_ttl_s & r_mask};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ts <= '0;
      r_fc <= '0;
    end else begin
      r_ts <= w_ts_next;
      r_fc <= w_capture ? '0 : w_fc_next;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_armed      <= 1'b0;
      r_mask       <= '0;
      r_fen        <= 1'b0;
      r_irq_status <= '0;
      r_smpl       <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_level      <= '0;
    end else begin
      if (w_wr_arm) begin
        r_armed      <= 1'b1;
        r_irq_status <= '0;
        r_smpl       <= '0;
        r_wp         <= '0;
        r_rp         <= '0;
        r_level      <= '0;
      end else begin
        if (w_complete) r_armed <= 1'b0;
        r_irq_status <= (r_irq_status & ~w_ack_mask) | {w_ovf, w_thr_set, w_complete};
        if (w_push) begin
          r_wp <= r_wp + c_ptr_w'(2);
          if (r_smpl != 16'hFFFF) r_smpl <= r_smpl + 16'd1;
        end
        if (w_pop) r_rp <= r_rp + c_ptr_w'(1);
        r_level <= w_level_next;
      end
      if (reg_wr && (reg_addr == c_addr_mask)) r_mask <= reg_wdata[5:0];
      if (reg_wr && (reg_addr == c_addr_fen))  r_fen  <= reg_wdata[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wp]  <= w_word0;
      r_mem[w_wp1] <= w_word1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (reg_addr)
      c_addr_mask:   w_rdata[5:0] = r_mask;
      c_addr_fen:    w_rdata[0]   = r_fen;
      c_addr_irq:    w_rdata      = {r_smpl, 13'b0, r_irq_status};
      c_addr_data:   if (r_level != '0) w_rdata = r_mem[r_rp];
      c_addr_smpl:   w_rdata[15:0] = r_smpl;
      c_addr_status: begin
        w_rdata[0]    = r_armed;
        w_rdata[1]    = r_ttl_s[0];
        w_rdata[13:8] = 6'(r_level);
      end
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     r_rdata <= '0;
    else if (reg_rd) r_rdata <= w_rdata;
  end

  assign reg_rdata = r_rdata;
  assign irq_o     = |r_irq_status;
  assign w_unused  = ^{reg_wdata[31:6], r_ttl_d[5:3], r_ttl_d[1]};

endmodule
`default_nettype wire

// File: tb/tb_panda_top_bench.sv
`default_nettype none
// Directed bench for panda_top_bench: register access, timestamp/frame capture,
// completion, threshold/overflow and asynchronous reset.
module tb_panda_top_bench;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [5:0]  ttlin_pad;
  logic        reg_wr, reg_rd;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_o;
  logic [31:0] d;
  int          n_checks = 0;
  int          n_errors = 0;

  panda_top_bench #(.FIFO_DEPTH(32), .THRESH(16)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ttlin_pad (ttlin_pad),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk_i);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = v;
    @(negedge clk_i);
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk_i);
    reg_rd = 1'b1; reg_addr = a;
    @(negedge clk_i);
    reg_rd = 1'b0;
    v = reg_rdata;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    reg_read(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic pulse_cap();
    ttlin_pad[2] = 1'b1;
    repeat (2) @(negedge clk_i);
    ttlin_pad[2] = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  // Gate rises now; capture pulses start 10 and 25 cycles after the gate edge
  task automatic gate_two_pulses();
    ttlin_pad[0] = 1'b1;
    repeat (10) @(negedge clk_i);
    ttlin_pad[2] = 1'b1;
    repeat (2) @(negedge clk_i);
    ttlin_pad[2] = 1'b0;
    repeat (13) @(negedge clk_i);
    ttlin_pad[2] = 1'b1;
    repeat (2) @(negedge clk_i);
    ttlin_pad[2] = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; ttlin_pad = '0; reg_wr = 1'b0; reg_rd = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    repeat (3) @(negedge clk_i);
    check_eq("reset_rdata", reg_rdata, 32'h0);
    check_eq("reset_irq", {31'b0, irq_o}, 32'h0);
    reset_i = 1'b0;

    read_check("rst_mask", 4'd2, 32'h0);
    read_check("rst_irqstat", 4'd4, 32'h0);
    read_check("rst_smpl", 4'd7, 32'h0);
    read_check("rst_status", 4'd8, 32'h0);
    read_check("unmapped", 4'd9, 32'h0);

    // Timestamp capture
    reg_write(4'd2, 32'hFFFF_FFFF);
    read_check("mask_rb", 4'd2, 32'h3F);
    reg_write(4'd0, 32'h0);
    gate_two_pulses();
    read_check("ts_smpl", 4'd7, 32'd2);
    read_check("ts_status", 4'd8, 32'h0000_0403);
    read_check("ts_w0a", 4'd6, 32'd10);
    read_check("ts_w1a", 4'd6, 32'h05);
    read_check("ts_w0b", 4'd6, 32'd25);
    read_check("ts_w1b", 4'd6, 32'h05);
    read_check("ts_empty", 4'd6, 32'h0);
    read_check("ts_status2", 4'd8, 32'h0000_0003);
    ttlin_pad[0] = 1'b0;
    repeat (6) @(negedge clk_i);
    read_check("ts_done", 4'd4, 32'h0002_0001);
    check_eq("ts_irq", {31'b0, irq_o}, 32'h1);
    read_check("ts_disarmed", 4'd8, 32'h0);

    // Frame-counter capture, then software disarm
    reg_write(4'd0, 32'h0);
    reg_write(4'd3, 32'h1);
    read_check("fen_rb", 4'd3, 32'h1);
    gate_two_pulses();
    read_check("fc_w0a", 4'd6, 32'd10);
    read_check("fc_w1a", 4'd6, 32'h05);
    read_check("fc_w0b", 4'd6, 32'd15);
    read_check("fc_w1b", 4'd6, 32'h05);
    reg_write(4'd1, 32'h0);
    read_check("disarm_irq", 4'd4, 32'h0002_0001);
    read_check("disarm_status", 4'd8, 32'h0000_0002);
    ttlin_pad[0] = 1'b0;
    reg_write(4'd3, 32'h0);
    reg_write(4'd5, 32'h7);

    // Completion on gate fall and acknowledge
    reg_write(4'd0, 32'h0);
    read_check("arm_status", 4'd8, 32'h1);
    check_eq("arm_irq", {31'b0, irq_o}, 32'h0);
    ttlin_pad[0] = 1'b1;
    repeat (5) @(negedge clk_i);
    ttlin_pad[0] = 1'b0;
    repeat (6) @(negedge clk_i);
    read_check("cmp_irqstat", 4'd4, 32'h1);
    check_eq("cmp_irq", {31'b0, irq_o}, 32'h1);
    read_check("cmp_status", 4'd8, 32'h0);
    reg_write(4'd5, 32'h1);
    check_eq("ack_irq", {31'b0, irq_o}, 32'h0);
    read_check("ack_irqstat", 4'd4, 32'h0);

    // Captures while disarmed are ignored
    ttlin_pad[0] = 1'b1;
    repeat (3) @(negedge clk_i);
    pulse_cap();
    repeat (2) @(negedge clk_i);
    read_check("dis_smpl", 4'd7, 32'h0);
    read_check("dis_status", 4'd8, 32'h2);
    ttlin_pad[0] = 1'b0;
    repeat (5) @(negedge clk_i);
    check_eq("dis_irq", {31'b0, irq_o}, 32'h0);

    // Threshold and overflow
    reg_write(4'd0, 32'h0);
    ttlin_pad[0] = 1'b1;
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 7; i++) pulse_cap();
    repeat (2) @(negedge clk_i);
    read_check("thr_7", 4'd4, 32'h0007_0000);
    check_eq("thr_7_irq", {31'b0, irq_o}, 32'h0);
    pulse_cap();
    repeat (2) @(negedge clk_i);
    read_check("thr_8", 4'd4, 32'h0008_0002);
    check_eq("thr_8_irq", {31'b0, irq_o}, 32'h1);
    for (int i = 0; i < 9; i++) pulse_cap();
    repeat (2) @(negedge clk_i);
    read_check("ovf_irqstat", 4'd4, 32'h0010_0006);
    read_check("ovf_smpl", 4'd7, 32'd16);
    read_check("ovf_status", 4'd8, 32'h0000_2003);
    read_check("ovf_w0", 4'd6, 32'd3);
    read_check("ovf_w1", 4'd6, 32'h05);
    read_check("ovf_status2", 4'd8, 32'h0000_1E03);
    reg_write(4'd5, 32'h6);
    read_check("ovf_ack", 4'd4, 32'h0010_0000);
    check_eq("ovf_ack_irq", {31'b0, irq_o}, 32'h0);

    // Refill to full, overflow again, then reset mid-acquisition
    pulse_cap();
    pulse_cap();
    repeat (2) @(negedge clk_i);
    read_check("pre_rst_irqstat", 4'd4, 32'h0011_0004);
    reg_read(4'd8, d);
    check_eq("pre_rst_status", d, 32'h0000_2003);
    check_eq("pre_rst_irq", {31'b0, irq_o}, 32'h1);
    reset_i = 1'b1;
    ttlin_pad = '0;
    #1;
    check_eq("mid_rst_rdata", reg_rdata, 32'h0);
    check_eq("mid_rst_irq", {31'b0, irq_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    read_check("post_rst_status", 4'd8, 32'h0);
    read_check("post_rst_smpl", 4'd7, 32'h0);
    read_check("post_rst_irq", 4'd4, 32'h0);
    read_check("post_rst_data", 4'd6, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
